// File: rtl/darkbus_demux.sv
// Registered address-decoding demux: one core bus to NSLV device buses,
// one outstanding transaction, per-transaction timeout and error responses.
module darkbus_demux #(
    parameter int unsigned           NSLV     = 3,
    parameter int unsigned           AW       = 32,
    parameter int unsigned           DW       = 32,
    parameter logic [NSLV*AW-1:0]    BASE     = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0]    MASK     = {32'hC000_0000, 32'hE000_0000, 32'hE000_0000},
    parameter int unsigned           TIMEOUT  = 255,
    parameter logic [DW-1:0]         ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 XCLK,
    input  logic                 XRES,
    input  logic                 CORE_EN,
    input  logic                 CORE_RE,
    input  logic                 CORE_WE,
    input  logic [DW/8-1:0]      CORE_BE,
    input  logic [AW-1:0]        CORE_ADDR,
    input  logic [DW-1:0]        CORE_WDATA,
    output logic [DW-1:0]        CORE_RDATA,
    output logic                 CORE_RACK,
    output logic                 CORE_WACK,
    output logic                 CORE_ERR,
    output logic [NSLV-1:0]      DEV_EN,
    output logic                 DEV_RE,
    output logic                 DEV_WE,
    output logic [DW/8-1:0]      DEV_BE,
    output logic [AW-1:0]        DEV_ADDR,
    output logic [DW-1:0]        DEV_WDATA,
    input  logic [NSLV*DW-1:0]   DEV_RDATA,
    input  logic [NSLV-1:0]      DEV_RACK,
    input  logic [NSLV-1:0]      DEV_WACK
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NSLV-1:0] dev_en_q, dev_en_d;
    logic            dev_re_q, dev_re_d;
    logic            dev_we_q, dev_we_d;
    logic [BW-1:0]   dev_be_q, dev_be_d;
    logic [AW-1:0]   dev_addr_q, dev_addr_d;
    logic [DW-1:0]   dev_wdata_q, dev_wdata_d;
    logic [DW-1:0]   core_rdata_q, core_rdata_d;
    logic            core_rack_q, core_rack_d;
    logic            core_wack_q, core_wack_d;
    logic            core_err_q, core_err_d;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [AW-1:0]   hit_off;
    logic            dev_ack;

    // Region decode; descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((CORE_ADDR & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
                hit_off = CORE_ADDR & ~MASK[i*AW +: AW];
            end
        end
    end

    assign dev_ack = dev_re_q ? DEV_RACK[sel_q] : DEV_WACK[sel_q];

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            dev_en_q     <= '0;
            dev_re_q     <= 1'b0;
            dev_we_q     <= 1'b0;
            dev_be_q     <= '0;
            dev_addr_q   <= '0;
            dev_wdata_q  <= '0;
            core_rdata_q <= '0;
            core_rack_q  <= 1'b0;
            core_wack_q  <= 1'b0;
            core_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            dev_en_q     <= dev_en_d;
            dev_re_q     <= dev_re_d;
            dev_we_q     <= dev_we_d;
            dev_be_q     <= dev_be_d;
            dev_addr_q   <= dev_addr_d;
            dev_wdata_q  <= dev_wdata_d;
            core_rdata_q <= core_rdata_d;
            core_rack_q  <= core_rack_d;
            core_wack_q  <= core_wack_d;
            core_err_q   <= core_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (CORE_EN) begin
                    if (CORE_RE && CORE_WE) begin
                        state_d = S_ERR;
                    end else if (CORE_RE || CORE_WE) begin
                        state_d = hit ? S_BUSY : S_ERR;
                    end
                end
            end
            S_BUSY: begin
                // A matching ack in the timeout cycle still completes normally.
                if (dev_ack) begin
                    state_d = S_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register inputs are computed from the transition so every output is a flop.
    always_comb begin
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        dev_en_d     = '0;
        dev_re_d     = dev_re_q;
        dev_we_d     = dev_we_q;
        dev_be_d     = dev_be_q;
        dev_addr_d   = dev_addr_q;
        dev_wdata_d  = dev_wdata_q;
        core_rdata_d = core_rdata_q;
        core_rack_d  = 1'b0;
        core_wack_d  = 1'b0;
        core_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_BUSY) begin
                    sel_d             = hit_idx;
                    dev_en_d[hit_idx] = 1'b1;
                    dev_re_d          = CORE_RE;
                    dev_we_d          = CORE_WE;
                    dev_be_d          = CORE_BE;
                    dev_addr_d        = hit_off;
                    dev_wdata_d       = CORE_WDATA;
                    cnt_d             = '0;
                end else if (state_d == S_ERR) begin
                    core_err_d   = 1'b1;
                    core_wack_d  = CORE_WE & ~CORE_RE;
                    core_rack_d  = ~(CORE_WE & ~CORE_RE);
                    core_rdata_d = ERR_DATA;
                end
            end
            S_BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_d == S_RESP) begin
                    core_rack_d = dev_re_q;
                    core_wack_d = dev_we_q;
                    if (dev_re_q) begin
                        core_rdata_d = DEV_RDATA[32'(sel_q)*DW +: DW];
                    end
                end else if (state_d == S_ERR) begin
                    core_err_d   = 1'b1;
                    core_wack_d  = dev_we_q;
                    core_rack_d  = ~dev_we_q;
                    core_rdata_d = ERR_DATA;
                end else begin
                    dev_en_d = dev_en_q;
                end
            end
            default: ;
        endcase
    end

    assign CORE_RDATA = core_rdata_q;
    assign CORE_RACK  = core_rack_q;
    assign CORE_WACK  = core_wack_q;
    assign CORE_ERR   = core_err_q;
    assign DEV_EN     = dev_en_q;
    assign DEV_RE     = dev_re_q;
    assign DEV_WE     = dev_we_q;
    assign DEV_BE     = dev_be_q;
    assign DEV_ADDR   = dev_addr_q;
    assign DEV_WDATA  = dev_wdata_q;

endmodule
